muldiv_hilo_unit: RTL
=====================

Name: muldiv_hilo_unit

Overview:
- Iterative multiply/accumulate unit with the architectural HI/LO register pair, sitting in EX directly downstream of the control decoder.
- Consumes the decoder's ALUOp/MULOp/Func outputs plus the two register operands.
- Executes MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MUL, MFHI, MFLO, MTHI and MTLO.
- Raises Stall so the pipeline holds any HI/LO-class instruction while a multiply is in flight.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- STEP_BITS, 1: multiplier bits retired per CALC cycle; must divide WIDTH. N = WIDTH/STEP_BITS.

Ports:
- Clock  input  1  system clock, rising edge.
- nReset  input  1  asynchronous, active-low reset.
- ALUOp  input  1  from decoder; qualifies SPECIAL-class Func (MULT, MULTU, MFHI, MFLO, MTHI, MTLO).
- MULOp  input  1  from decoder; qualifies SPECIAL2-class Func (MADD, MADDU, MSUB, MSUBU, MUL).
- Func  input  6  function code from decoder.
- A  input  WIDTH  rs operand.
- B  input  WIDTH  rt operand.
- Result  output  WIDTH  MFHI/MFLO data (combinational) or MUL low word (during FIX).
- Done  output  1  one-cycle pulse in FIX.
- Busy  output  1  state != IDLE.
- Stall  output  1  pipeline hold request.
- HI  output  WIDTH  architectural HI register.
- LO  output  WIDTH  architectural LO register.

Behaviour:
- Reset (async, nReset=0): state=IDLE, HI=LO=0, Result=0, Done=0, Busy=0, Stall=0, counter and datapath registers cleared. Reset mid-operation aborts the operation; no HI/LO write occurs.
- Request decode: ALUOp selects the SPECIAL codes and MULOp the SPECIAL2 codes. MADD=000000 and SLL=000000 are disambiguated only by MULOp. Any other Func, or neither op asserted, is a no-op.
- Accept condition: a mult-class request (MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MUL) in IDLE is accepted at that clock edge.
- Stall = Busy AND (any valid HI/LO-class request); combinational. Stalled requests are held by the pipeline and re-evaluated each cycle. Stall is never asserted in IDLE.
- State machine IDLE -> CALC -> FIX -> IDLE:
  - IDLE -> CALC on accept. Latch |A| and |B| (signed ops) or A and B raw (unsigned ops), the negate flag (signed and A[WIDTH-1]^B[WIDTH-1]), the op, and counter=0.
  - CALC: each cycle adds STEP_BITS partial products into a 2*WIDTH accumulator and shifts. After N cycles (counter==N-1) go to FIX.
  - FIX (1 cycle): apply two's-complement negate if flagged, giving P (2*WIDTH bits). Done=1.
    - MULT/MULTU: {HI,LO} <= P.
    - MADD/MADDU: {HI,LO} <= {HI,LO} + P.
    - MSUB/MSUBU: {HI,LO} <= {HI,LO} - P.
    - MUL: Result = P[WIDTH-1:0]; HI/LO unchanged.
    - All 2*WIDTH arithmetic wraps modulo 2^(2*WIDTH); no overflow flag.
    - HI/LO update at the FIX->IDLE edge.
- Latency: accept at edge E0; Busy high for N+1 cycles (33 at defaults); Done in cycle N+1 after E0. A HI/LO request presented during FIX stalls one cycle, then sees the new value.
- MFHI/MFLO in IDLE: Result = HI/LO combinationally, same cycle, no state change.
- MTHI/MTLO in IDLE: HI/LO <= A at the clock edge. A later MFHI/MFLO sees the new value.
- Result is 0 whenever not driven by MFHI, MFLO, or MUL in FIX.
- Back-to-back: a new mult request in the FIX cycle stalls and is accepted on the following IDLE edge; there is no overlap.

Decomposition:
- Shared package (extend the existing mul/op definitions):
  - SPECIAL and SPECIAL2 function-code constants (MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, MADD 000000, MADDU 000001, MUL 000010, MSUB 000100, MSUBU 000101).
  - State enum {IDLE, CALC, FIX}.
  - Op-class enum {OP_MULT, OP_MADD, OP_MSUB, OP_MUL}.
- Sub-module mul_step: combinational STEP_BITS-wide shift-add step (accumulator, multiplicand, multiplier slice in; next accumulator out), instantiated once in the CALC datapath.

Test Plan:
- MULT A=FFFFFFFD (-3), B=00000005 -> Busy 33 cycles, Done pulse; then HI=FFFFFFFF, LO=FFFFFFF1.
- MULTU A=B=FFFFFFFF -> HI=FFFFFFFE, LO=00000001. Repeat with STEP_BITS=2 -> same result, Busy 17 cycles.
- MTHI 0, MTLO 0000000A, then MADD 2*3 -> LO=00000010, HI=0. Then MSUBU 00000001*00000011 -> HI=FFFFFFFF, LO=FFFFFFFF.
- MUL 7*(-2) with HI=12345678, LO=9ABCDEF0 -> Result=FFFFFFF2 in the Done cycle; HI/LO unchanged.
- MFHI issued the cycle after MULT accept -> Stall high through FIX; MFHI then returns the new HI. An SLL with ALUOp (Func=000000) during Busy -> Stall stays low.
- nReset pulsed low mid-CALC of MULT 5*5 -> Busy, Done and Stall drop immediately; HI=LO=0; no Done pulse afterwards.

Source files
------------

// File: rtl/muldiv_hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply unit: function codes,
// state and op-class enums, and the request decoder.
package muldiv_hilo_unit_pkg;

  // SPECIAL-class function codes (qualified by ALUOp)
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;

  // SPECIAL2-class function codes (qualified by MULOp)
  localparam logic [5:0] FN_MADD  = 6'b000000;
  localparam logic [5:0] FN_MADDU = 6'b000001;
  localparam logic [5:0] FN_MUL   = 6'b000010;
  localparam logic [5:0] FN_MSUB  = 6'b000100;
  localparam logic [5:0] FN_MSUBU = 6'b000101;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  typedef enum logic [1:0] {OP_MULT, OP_MADD, OP_MSUB, OP_MUL} op_t;

  typedef struct packed {
    logic valid;       // any HI/LO-class request
    logic mult_class;  // starts the iterative multiplier
    logic is_signed;
    op_t  op;
    logic mfhi;
    logic mflo;
    logic mthi;
    logic mtlo;
  } req_t;

  // MADD and SLL share 000000; only the qualifying op bit tells them apart,
  // so each class is matched strictly under its own qualifier.
  function automatic req_t decode_req(input logic alu_op, input logic mul_op,
                                      input logic [5:0] func);
    req_t r;
    r    = '0;
    r.op = OP_MULT;
    if (alu_op) begin
      case (func)
        FN_MFHI:  r.mfhi = 1'b1;
        FN_MFLO:  r.mflo = 1'b1;
        FN_MTHI:  r.mthi = 1'b1;
        FN_MTLO:  r.mtlo = 1'b1;
        FN_MULT:  begin r.mult_class = 1'b1; r.is_signed = 1'b1; r.op = OP_MULT; end
        FN_MULTU: begin r.mult_class = 1'b1; r.op = OP_MULT; end
        default:  ;
      endcase
    end
    if (mul_op) begin
      case (func)
        FN_MADD:  begin r.mult_class = 1'b1; r.is_signed = 1'b1; r.op = OP_MADD; end
        FN_MADDU: begin r.mult_class = 1'b1; r.op = OP_MADD; end
        FN_MSUB:  begin r.mult_class = 1'b1; r.is_signed = 1'b1; r.op = OP_MSUB; end
        FN_MSUBU: begin r.mult_class = 1'b1; r.op = OP_MSUB; end
        FN_MUL:   begin r.mult_class = 1'b1; r.is_signed = 1'b1; r.op = OP_MUL; end
        default:  ;
      endcase
    end
    r.valid = r.mult_class | r.mfhi | r.mflo | r.mthi | r.mtlo;
    return r;
  endfunction

endpackage

// File: rtl/muldiv_hilo_unit_mul_step.sv
// One iteration of a right-shifting shift-add multiplier: adds STEP_BITS
// partial products into the upper half of the accumulator, then shifts the
// whole accumulator right by STEP_BITS.
module muldiv_hilo_unit_mul_step #(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 1
) (
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [STEP_BITS-1:0] mplier_slice,
  output logic [2*WIDTH-1:0]   acc_out
);

  // Upper half plus partial products cannot exceed WIDTH+STEP_BITS bits.
  logic [WIDTH+STEP_BITS-1:0] psum [STEP_BITS+1];

  assign psum[0] = {{STEP_BITS{1'b0}}, acc_in[2*WIDTH-1:WIDTH]};

  // Chain of conditional adds, one per multiplier bit in the slice
  for (genvar gi = 0; gi < STEP_BITS; gi++) begin : g_pp
    assign psum[gi+1] = psum[gi] +
      (mplier_slice[gi] ? ({{STEP_BITS{1'b0}}, mcand} << gi) : '0);
  end

  assign acc_out = (2*WIDTH)'({psum[STEP_BITS], acc_in[WIDTH-1:0]} >> STEP_BITS);

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/accumulate unit owning the HI/LO register pair.
// Multiplies unsigned magnitudes over N = WIDTH/STEP_BITS cycles, then fixes
// the sign and commits to HI/LO (or presents the MUL low word) in one cycle.
module muldiv_hilo_unit
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 1
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             ALUOp,
  input  logic             MULOp,
  input  logic [5:0]       Func,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Done,
  output logic             Busy,
  output logic             Stall,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int N  = WIDTH / STEP_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic               neg_q, neg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  req_t               req;
  logic               accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] hilo_fix;

  assign req    = decode_req(ALUOp, MULOp, Func);
  assign accept = (state_q == IDLE) && req.mult_class;
  assign a_mag  = (req.is_signed && A[WIDTH-1]) ? -A : A;
  assign b_mag  = (req.is_signed && B[WIDTH-1]) ? -B : B;

  muldiv_hilo_unit_mul_step #(
    .WIDTH     (WIDTH),
    .STEP_BITS (STEP_BITS)
  ) u_mul_step (
    .acc_in       (acc_q),
    .mcand        (mcand_q),
    .mplier_slice (mplier_q[STEP_BITS-1:0]),
    .acc_out      (step_acc)
  );

  // Signed product and the HI/LO value committed at the end of FIX
  always_comb begin
    prod     = neg_q ? -acc_q : acc_q;
    hilo_fix = {hi_q, lo_q};
    case (op_q)
      OP_MULT: hilo_fix = prod;
      OP_MADD: hilo_fix = {hi_q, lo_q} + prod;
      OP_MSUB: hilo_fix = {hi_q, lo_q} - prod;
      OP_MUL:  hilo_fix = {hi_q, lo_q};
    endcase
  end

  // Next-state logic for the IDLE -> CALC -> FIX sequence and HI/LO writes
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = CALC;
          op_d     = req.op;
          neg_d    = req.is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = a_mag;
          mplier_d = b_mag;
        end else begin
          if (req.mthi) hi_d = A;
          if (req.mtlo) lo_d = A;
        end
      end
      CALC: begin
        acc_d    = step_acc;
        mplier_d = mplier_q >> STEP_BITS;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = FIX;
      end
      FIX: begin
        state_d      = IDLE;
        {hi_d, lo_d} = hilo_fix;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      op_q     <= OP_MULT;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Status outputs and the shared Result bus
  always_comb begin
    Busy   = (state_q != IDLE);
    Done   = (state_q == FIX);
    Stall  = Busy && req.valid;
    Result = '0;
    if (state_q == IDLE) begin
      if (req.mfhi)      Result = hi_q;
      else if (req.mflo) Result = lo_q;
    end else if (state_q == FIX && op_q == OP_MUL) begin
      Result = prod[WIDTH-1:0];
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule
